// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory and mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding environment.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            im_req_i;
  logic [XLEN-1:0] im_addr_i;
  logic            im_gnt_o;
  logic            im_rvalid_o;
  logic [XLEN-1:0] im_rdata_o;

  logic            dm_req_i;
  logic            dm_wen_i;
  logic [XLEN-1:0] dm_addr_i;
  logic [XLEN-1:0] dm_wdata_i;
  logic            dm_gnt_o;
  logic            dm_rvalid_o;
  logic [XLEN-1:0] dm_rdata_o;

  logic            mem_en_o;
  logic            mem_wen_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  im_req_i, im_addr_i,
    output im_gnt_o, im_rvalid_o, im_rdata_o,
    input  dm_req_i, dm_wen_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_en_o, mem_wen_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output im_req_i, im_addr_i,
    input  im_gnt_o, im_rvalid_o, im_rdata_o,
    output dm_req_i, dm_wen_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_en_o, mem_wen_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch (IM)
// and data (DM) requesters; one access in flight, next grant overlaps the response.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int            CW  = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {IM, DM}     owner_t;

  typedef struct packed {
    logic            en;
    logic            wen;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  owner_t        own, own_nxt;
  owner_t        last, last_nxt;

  logic     done;
  logic     can_gnt;
  logic     pick_dm;
  logic     gnt_im;
  logic     gnt_dm;
  logic     rv_im;
  logic     rv_dm;
  mem_cmd_t cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      own   <= IM;
      last  <= IM;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      own   <= own_nxt;
      last  <= last_nxt;
    end
  end

  // Grant is gated by rst_n so asserting reset silences the bus in the same instant.
  always_comb begin
    done    = (state == BUSY) && (cnt == LAT);
    can_gnt = rst_n && ((state == IDLE) || done);
    pick_dm = bus.dm_req_i && (!bus.im_req_i || (last == IM));
    gnt_dm  = can_gnt && pick_dm;
    gnt_im  = can_gnt && bus.im_req_i && !pick_dm;
    rv_im   = done && (own == IM);
    rv_dm   = done && (own == DM);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    own_nxt   = own;
    last_nxt  = last;
    if (gnt_im || gnt_dm) begin
      state_nxt = BUSY;
      cnt_nxt   = ONE;
      own_nxt   = gnt_dm ? DM : IM;
      last_nxt  = gnt_dm ? DM : IM;
    end else if (done) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == BUSY) begin
      cnt_nxt = cnt + ONE;
    end
  end

  // Memory command mux: zeroed whenever nothing is granted.
  always_comb begin
    cmd = '0;
    if (gnt_dm) begin
      cmd.en    = 1'b1;
      cmd.wen   = bus.dm_wen_i;
      cmd.addr  = bus.dm_addr_i;
      cmd.wdata = bus.dm_wdata_i;
    end else if (gnt_im) begin
      cmd.en    = 1'b1;
      cmd.addr  = bus.im_addr_i;
    end
  end

  assign bus.im_gnt_o    = gnt_im;
  assign bus.dm_gnt_o    = gnt_dm;
  assign bus.im_rvalid_o = rv_im;
  assign bus.dm_rvalid_o = rv_dm;
  assign bus.im_rdata_o  = rv_im ? bus.mem_rdata_i : '0;
  assign bus.dm_rdata_o  = rv_dm ? bus.mem_rdata_i : '0;
  assign bus.mem_en_o    = cmd.en;
  assign bus.mem_wen_o   = cmd.wen;
  assign bus.mem_addr_o  = cmd.addr;
  assign bus.mem_wdata_o = cmd.wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (MEM_LAT 1..3) checked every cycle against a timestamp-based
// model of grants and responses, plus directed literal expectations.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int N    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    rst;
  logic [N-1:0]    im_req, dm_req, dm_wen;
  logic [XLEN-1:0] im_addr [N];
  logic [XLEN-1:0] dm_addr [N];
  logic [XLEN-1:0] dm_wdata[N];
  logic [XLEN-1:0] mem_rdata[N];

  logic [N-1:0]    im_gnt, im_rv, dm_gnt, dm_rv, m_en, m_wen;
  logic [XLEN-1:0] im_rd  [N];
  logic [XLEN-1:0] dm_rd  [N];
  logic [XLEN-1:0] m_addr [N];
  logic [XLEN-1:0] m_wdata[N];

  for (genvar g = 0; g < N; g++) begin : gi
    mem_arbiter_if #(.XLEN(XLEN)) bus ();
    mem_arbiter #(.XLEN(XLEN), .MEM_LAT(g + 1)) dut (
      .clk  (clk),
      .rst_n(rst[g]),
      .bus  (bus)
    );
    assign bus.im_req_i    = im_req[g];
    assign bus.im_addr_i   = im_addr[g];
    assign bus.dm_req_i    = dm_req[g];
    assign bus.dm_wen_i    = dm_wen[g];
    assign bus.dm_addr_i   = dm_addr[g];
    assign bus.dm_wdata_i  = dm_wdata[g];
    assign bus.mem_rdata_i = mem_rdata[g];
    assign im_gnt[g]  = bus.im_gnt_o;
    assign im_rv[g]   = bus.im_rvalid_o;
    assign im_rd[g]   = bus.im_rdata_o;
    assign dm_gnt[g]  = bus.dm_gnt_o;
    assign dm_rv[g]   = bus.dm_rvalid_o;
    assign dm_rd[g]   = bus.dm_rdata_o;
    assign m_en[g]    = bus.mem_en_o;
    assign m_wen[g]   = bus.mem_wen_o;
    assign m_addr[g]  = bus.mem_addr_o;
    assign m_wdata[g] = bus.mem_wdata_o;
  end

  // Model: an access granted in cycle t answers in cycle t+LAT; the port is free
  // when nothing is outstanding or the outstanding one answers this cycle.
  int lat[N] = '{1, 2, 3};
  int cyc;
  bit pend[N];
  int resp_t[N];
  bit own_dm[N];
  bit last_dm[N];
  bit egim[N];
  bit egdm[N];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input int g, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s[%0d] cyc %0d: got %h want %h", nm, g, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic sample();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      bit rv, free;
      logic [XLEN-1:0] ea;
      rv      = rst[g] && pend[g] && (resp_t[g] == cyc);
      free    = rst[g] && (!pend[g] || (resp_t[g] == cyc));
      egdm[g] = free && dm_req[g] && (!im_req[g] || !last_dm[g]);
      egim[g] = free && im_req[g] && !egdm[g];
      ea      = egdm[g] ? dm_addr[g] : (egim[g] ? im_addr[g] : '0);
      chk("im_gnt",    g, 32'(im_gnt[g]), 32'(egim[g]));
      chk("dm_gnt",    g, 32'(dm_gnt[g]), 32'(egdm[g]));
      chk("mem_en",    g, 32'(m_en[g]),   32'(egim[g] | egdm[g]));
      chk("mem_wen",   g, 32'(m_wen[g]),  32'(egdm[g] & dm_wen[g]));
      chk("mem_addr",  g, m_addr[g],  ea);
      chk("mem_wdata", g, m_wdata[g], egdm[g] ? dm_wdata[g] : '0);
      chk("im_rvalid", g, 32'(im_rv[g]), 32'(rv && !own_dm[g]));
      chk("dm_rvalid", g, 32'(dm_rv[g]), 32'(rv && own_dm[g]));
      chk("im_rdata",  g, im_rd[g], (rv && !own_dm[g]) ? mem_rdata[g] : '0);
      chk("dm_rdata",  g, dm_rd[g], (rv && own_dm[g]) ? mem_rdata[g] : '0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int g = 0; g < N; g++) begin
      if (!rst[g]) begin
        pend[g] = 0; own_dm[g] = 0; last_dm[g] = 0;
      end else begin
        if (pend[g] && resp_t[g] == cyc) pend[g] = 0;
        if (egim[g] || egdm[g]) begin
          pend[g]    = 1;
          resp_t[g]  = cyc + lat[g];
          own_dm[g]  = egdm[g];
          last_dm[g] = egdm[g];
        end
      end
    end
    cyc++;
    #1;
    for (int g = 0; g < N; g++) mem_rdata[g] = {cyc[15:0], 8'(g), 8'hA5};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    rst = '0; im_req = '1; dm_req = '0; dm_wen = '0;
    for (int g = 0; g < N; g++) begin
      im_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0;
      mem_rdata[g] = 32'h0BAD_0000 + 32'(g);
      pend[g] = 0; resp_t[g] = 0; own_dm[g] = 0; last_dm[g] = 0;
      egim[g] = 0; egdm[g] = 0;
    end

    // Reset: requests are high but nothing may be granted.
    repeat (2) begin
      sample();
      for (int g = 0; g < N; g++) begin
        chk("rst_gnt", g, 32'(im_gnt[g]), 32'd0);
        chk("rst_en",  g, 32'(m_en[g]),   32'd0);
      end
      step();
    end
    im_req = 3'b001; im_addr[0] = 32'h100; rst = '1;

    // Fetch streaming at MEM_LAT=1, first grant right after release.
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("a_gnt", 0, 32'(im_gnt[0]), 32'd1);
      chk("a_addr", 0, m_addr[0], 32'h100);
      if (i > 0) chk("a_rv", 0, 32'(im_rv[0]), 32'd1);
      step();
    end
    im_req[0] = 1'b0;
    sample();
    chk("a_rv_last", 0, 32'(im_rv[0]), 32'd1);
    chk("a_gnt_off", 0, 32'(im_gnt[0]), 32'd0);
    step();

    // Round-robin after a fresh reset: DM first.
    rst[0] = 1'b0;
    sample(); step();
    rst[0] = 1'b1;
    im_req[0] = 1; dm_req[0] = 1; dm_wen[0] = 1;
    im_addr[0] = 32'h104; dm_addr[0] = 32'h40; dm_wdata[0] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("b_dm_gnt", 0, 32'(dm_gnt[0]), 32'(i % 2 == 0));
      chk("b_im_gnt", 0, 32'(im_gnt[0]), 32'(i % 2 == 1));
      chk("b_wen",    0, 32'(m_wen[0]),  32'(i % 2 == 0));
      step();
    end
    im_req[0] = 0; dm_req[0] = 0; dm_wen[0] = 0;
    sample(); step();

    // MEM_LAT=3 write; fetch waiting must not be granted until the ack cycle.
    dm_req[2] = 1; dm_wen[2] = 1; dm_addr[2] = 32'h20; dm_wdata[2] = 32'hDEADBEEF;
    sample();
    chk("c_gnt",   2, 32'(dm_gnt[2]), 32'd1);
    chk("c_wen",   2, 32'(m_wen[2]),  32'd1);
    chk("c_addr",  2, m_addr[2],  32'h20);
    chk("c_wdata", 2, m_wdata[2], 32'hDEADBEEF);
    step();
    dm_req[2] = 0; dm_wen[2] = 0; im_req[2] = 1; im_addr[2] = 32'h30;
    for (int i = 1; i <= 2; i++) begin
      sample();
      chk("c_gap_gnt", 2, 32'(im_gnt[2] | dm_gnt[2]), 32'd0);
      chk("c_gap_en",  2, 32'(m_en[2]),  32'd0);
      chk("c_gap_rv",  2, 32'(dm_rv[2]), 32'd0);
      step();
    end
    sample();
    chk("c_ack",    2, 32'(dm_rv[2]),  32'd1);
    chk("c_im_gnt", 2, 32'(im_gnt[2]), 32'd1);
    chk("c_im_wen", 2, 32'(m_wen[2]),  32'd0);
    step();
    im_req[2] = 0;
    repeat (3) begin sample(); step(); end

    // MEM_LAT=2: reset while an IM fetch is outstanding drops it.
    im_req[1] = 1; im_addr[1] = 32'h200;
    sample();
    chk("d_gnt", 1, 32'(im_gnt[1]), 32'd1);
    step();
    im_req[1] = 0; dm_req[1] = 1;
    #2 rst[1] = 1'b0;
    #1;
    chk("d_async_gnt", 1, 32'(dm_gnt[1]), 32'd0);
    chk("d_async_en",  1, 32'(m_en[1]),   32'd0);
    chk("d_async_rv",  1, 32'(im_rv[1]),  32'd0);
    sample(); step();
    rst[1] = 1'b1; dm_req[1] = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("d_no_rv", 1, 32'(im_rv[1]), 32'd0);
      step();
    end

    // MEM_LAT=2: IM granted in the same cycle DM's data returns.
    dm_req[1] = 1; dm_wen[1] = 0; dm_addr[1] = 32'h300;
    sample();
    chk("e_dm_gnt", 1, 32'(dm_gnt[1]), 32'd1);
    step();
    dm_req[1] = 0; im_req[1] = 1; im_addr[1] = 32'h304;
    sample();
    chk("e_wait", 1, 32'(im_gnt[1]), 32'd0);
    step();
    sample();
    chk("e_dm_rv",  1, 32'(dm_rv[1]),  32'd1);
    chk("e_im_gnt", 1, 32'(im_gnt[1]), 32'd1);
    chk("e_addr",   1, m_addr[1], 32'h304);
    step();
    im_req[1] = 0;
    sample();
    chk("e_im_rv0", 1, 32'(im_rv[1]), 32'd0);
    step();
    sample();
    chk("e_im_rv", 1, 32'(im_rv[1]), 32'd1);
    step();

    // Mixed traffic on all three instances, including withdrawn requests.
    for (int i = 0; i < 80; i++) begin
      for (int g = 0; g < N; g++) begin
        im_req[g]   = 1'($urandom_range(0, 1));
        dm_req[g]   = 1'($urandom_range(0, 1));
        dm_wen[g]   = 1'($urandom_range(0, 1));
        im_addr[g]  = $urandom;
        dm_addr[g]  = $urandom;
        dm_wdata[g] = $urandom;
      end
      sample(); step();
    end
    im_req = '0; dm_req = '0; dm_wen = '0;
    repeat (4) begin sample(); step(); end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address and data width.
REQ-002 The block SHALL have parameter MEM_LAT, default 1, legal range 1-4, meaning cycles from memory command to mem_rdata_i valid.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have im_req_i, input, 1 bit: instruction-fetch read request.
REQ-006 The block SHALL have im_addr_i, input, XLEN bits: fetch address.
REQ-007 The block SHALL have im_gnt_o, output, 1 bit: fetch request accepted this cycle.
REQ-008 The block SHALL have im_rvalid_o, output, 1 bit: fetch data valid.
REQ-009 The block SHALL have im_rdata_o, output, XLEN bits: fetch data.
REQ-010 The block SHALL have dm_req_i, input, 1 bit: data access request.
REQ-011 The block SHALL have dm_wen_i, input, 1 bit: 1 = write, 0 = read.
REQ-012 The block SHALL have dm_addr_i, input, XLEN bits: data address.
REQ-013 The block SHALL have dm_wdata_i, input, XLEN bits: write data.
REQ-014 The block SHALL have dm_gnt_o, output, 1 bit: data request accepted this cycle.
REQ-015 The block SHALL have dm_rvalid_o, output, 1 bit: read data valid, or write acknowledge.
REQ-016 The block SHALL have dm_rdata_o, output, XLEN bits: read data.
REQ-017 The block SHALL have mem_en_o, output, 1 bit: active-high memory command strobe.
REQ-018 The block SHALL have mem_wen_o, output, 1 bit: 1 = write command.
REQ-019 The block SHALL have mem_addr_o, output, XLEN bits: memory address.
REQ-020 The block SHALL have mem_wdata_o, output, XLEN bits: memory write data.
REQ-021 The block SHALL have mem_rdata_i, input, XLEN bits: memory read data, valid MEM_LAT cycles after mem_en_o.

Function
REQ-022 The controller SHALL use states IDLE and BUSY, a latency counter cnt (0..MEM_LAT), an owner flag own (IM/DM), and a last-grant pointer last.
REQ-023 Grant SHALL be combinational and SHALL be given in one of two cases: in IDLE, or in BUSY when cnt==MEM_LAT. At most one gnt SHALL be high per cycle.
REQ-024 Only one requester SHALL request: it SHALL be granted.
REQ-025 Both requesters SHALL request: the one not equal to last SHALL be granted (round-robin); last SHALL reset to IM, so DM wins the first conflict.
REQ-026 In the grant cycle, mem_en_o SHALL be 1 and mem_addr_o/mem_wen_o/mem_wdata_o SHALL be driven from the granted requester. For IM: mem_wen_o = 0 and mem_wdata_o = 0.
REQ-027 With no grant, mem_en_o, mem_wen_o, mem_addr_o and mem_wdata_o SHALL all be 0.
REQ-028 On a grant, next-state SHALL be BUSY with cnt = 1 and own = grantee, and last SHALL be updated to the grantee.
REQ-029 In BUSY with cnt<MEM_LAT, cnt SHALL increment and no grant SHALL issue.
REQ-030 In BUSY with cnt==MEM_LAT, the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata_i. Next state SHALL be BUSY (cnt = 1) if a new grant issues that cycle, else IDLE.
REQ-031 rvalid SHALL pulse for exactly one cycle per grant, including DM writes; rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-032 Latency from gnt to rvalid SHALL be exactly MEM_LAT cycles. Sustained throughput SHALL be one access per MEM_LAT cycles, so MEM_LAT=1 gives back-to-back grants every cycle.
REQ-033 A requester SHALL hold req, addr, wen and wdata stable until its gnt. Deasserting req before gnt SHALL withdraw it with no side effect.
REQ-034 Simultaneous rvalid to one owner and grant to the other in the same cycle SHALL be legal and SHALL be handled as defined in REQ-030.

Reset
REQ-035 On rst_n low, the block SHALL asynchronously force state = IDLE, cnt = 0, own = IM, last = IM, and all outputs to 0.
REQ-036 Reset asserted during BUSY SHALL drop the outstanding access: no rvalid SHALL be produced for it after release.
REQ-037 The first grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Verification
REQ-038 MEM_LAT=1, im_req_i=1 held, im_addr_i=0x100 -> im_gnt_o every cycle; im_rvalid_o one cycle after each gnt, with im_rdata_o = mem_rdata_i.
REQ-039 MEM_LAT=1, after reset both requests high -> grant order DM, IM, DM, IM; mem_wen_o follows dm_wen_i only on DM cycles.
REQ-040 MEM_LAT=3, dm write addr 0x20 data 0xDEADBEEF -> mem_en_o=1, mem_wen_o=1 for one cycle; dm_rvalid_o at +3 cycles; no grant at +1 or +2.
REQ-041 MEM_LAT=2, rst_n pulsed low one cycle after an IM grant -> outputs 0 immediately; no im_rvalid_o after release.
REQ-042 MEM_LAT=2, IM pending during dm_rvalid_o cycle -> im_gnt_o in that same cycle; im_rvalid_o 2 cycles later.
